// File: rtl/wash_cycle_sequencer.sv
// Wash cycle sequencer: fill, wash, drain, rinse, dry with pause,
// abort, sensor timeouts and a registered actuator/status decode.
module wash_cycle_sequencer #(
   parameter int TW          = 8,
   parameter int T_WASH      = 20,
   parameter int T_RINSE     = 10,
   parameter int T_DRY       = 15,
   parameter int T_FILL_MAX  = 30,
   parameter int T_DRAIN_MAX = 30
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          tick,
   input  logic          start,
   input  logic          pause,
   input  logic          abort,
   input  logic          door_closed,
   input  logic          lvl_high,
   input  logic          lvl_low,
   output logic          valve_in,
   output logic          pump_wash,
   output logic          pump_drain,
   output logic          heater,
   output logic          fan,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [2:0]    phase,
   output logic [TW-1:0] remaining
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FILL  = 3'd1,
      S_WASH  = 3'd2,
      S_DRAIN = 3'd3,
      S_RINSE = 3'd4,
      S_DRY   = 3'd5,
      S_DONE  = 3'd6,
      S_ERROR = 3'd7
   } state_e;

   localparam logic [TW-1:0] TMR_MAX    = '1;
   localparam logic [TW-1:0] WASH_LAST  = TW'(T_WASH - 1);
   localparam logic [TW-1:0] RINSE_LAST = TW'(T_RINSE - 1);
   localparam logic [TW-1:0] DRY_LAST   = TW'(T_DRY - 1);
   localparam logic [TW-1:0] FILL_LAST  = TW'(T_FILL_MAX - 1);
   localparam logic [TW-1:0] DRAIN_LAST = TW'(T_DRAIN_MAX - 1);

   state_e        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          pass_q, pass_d;
   logic          abort_flag_q, abort_flag_d;
   logic          paused_q, paused_d;
   logic          active;

   // a cycle is in progress (FILL through DRY)
   assign active = (state_q == S_FILL)  || (state_q == S_WASH) ||
                   (state_q == S_DRAIN) || (state_q == S_RINSE) ||
                   (state_q == S_DRY);

   // next-state, pass/abort bookkeeping and the phase timer
   always_comb begin
      state_d      = state_q;
      pass_d       = pass_q;
      abort_flag_d = abort_flag_q;
      timer_d      = timer_q;
      paused_d     = active & (pause | ~door_closed);

      if (abort) begin
         unique case (state_q)
            S_FILL, S_WASH, S_RINSE, S_DRY: begin
               state_d      = S_DRAIN;
               abort_flag_d = 1'b1;
            end
            S_DRAIN: abort_flag_d = 1'b1;
            S_ERROR: state_d = S_IDLE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = state_q;
         endcase
      end else if (!paused_q) begin
         unique case (state_q)
            S_IDLE: begin
               if (start && door_closed) begin
                  state_d = S_FILL;
                  pass_d  = 1'b0;
               end
            end
            S_FILL: begin
               if (lvl_high) begin
                  state_d = pass_q ? S_RINSE : S_WASH;
               end else if (tick && timer_q == FILL_LAST) begin
                  state_d = S_ERROR;
               end
            end
            S_WASH: begin
               if (tick && timer_q == WASH_LAST) state_d = S_DRAIN;
            end
            S_RINSE: begin
               if (tick && timer_q == RINSE_LAST) state_d = S_DRAIN;
            end
            S_DRY: begin
               if (tick && timer_q == DRY_LAST) state_d = S_DONE;
            end
            S_DRAIN: begin
               if (lvl_low) begin
                  if (abort_flag_q) begin
                     state_d = S_IDLE;
                  end else if (!pass_q) begin
                     state_d = S_FILL;
                     pass_d  = 1'b1;
                  end else begin
                     state_d = S_DRY;
                  end
               end else if (tick && timer_q == DRAIN_LAST) begin
                  state_d = S_ERROR;
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = state_q;
         endcase
      end

      // returning to idle ends any aborted cycle
      if (state_d == S_IDLE) abort_flag_d = 1'b0;

      if (state_d != state_q) begin
         timer_d = '0;
      end else if (tick && !paused_q && timer_q != TMR_MAX) begin
         timer_d = timer_q + 1'b1;
      end
   end

   // state register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         timer_q      <= '0;
         pass_q       <= 1'b0;
         abort_flag_q <= 1'b0;
         paused_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         pass_q       <= pass_d;
         abort_flag_q <= abort_flag_d;
         paused_q     <= paused_d;
      end
   end

   // outputs decoded from registered state only
   always_comb begin
      valve_in   = 1'b0;
      pump_wash  = 1'b0;
      pump_drain = 1'b0;
      heater     = 1'b0;
      fan        = 1'b0;
      remaining  = '0;
      phase      = state_q;
      busy       = active;
      done       = (state_q == S_DONE);
      err        = (state_q == S_ERROR);

      if (!paused_q) begin
         unique case (state_q)
            S_FILL:  valve_in = 1'b1;
            S_WASH: begin
               pump_wash = 1'b1;
               heater    = 1'b1;
            end
            S_RINSE: pump_wash = 1'b1;
            S_DRAIN: pump_drain = 1'b1;
            S_DRY: begin
               fan    = 1'b1;
               heater = 1'b1;
            end
            default: valve_in = 1'b0;
         endcase
      end

      unique case (state_q)
         S_WASH:  remaining = TW'(T_WASH) - timer_q;
         S_RINSE: remaining = TW'(T_RINSE) - timer_q;
         S_DRY:   remaining = TW'(T_DRY) - timer_q;
         default: remaining = '0;
      endcase
   end

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Bench for wash_cycle_sequencer: vector table, directed corner
// sequences and random stimulus against a behavioural model.
module tb_wash_cycle_sequencer;

   localparam int TW   = 8;
   localparam int TWSH = 4;
   localparam int TRNS = 3;
   localparam int TDRY = 2;
   localparam int TFIL = 5;
   localparam int TDRN = 5;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic tick = 1'b0, start = 1'b0, pause = 1'b0, abort = 1'b0;
   logic door_closed = 1'b1, lvl_high = 1'b0, lvl_low = 1'b0;
   logic valve_in, pump_wash, pump_drain, heater, fan;
   logic busy, done, err;
   logic [2:0] phase;
   logic [TW-1:0] remaining;

   int n_chk = 0;
   int n_fail = 0;

   wash_cycle_sequencer #(
      .TW(TW), .T_WASH(TWSH), .T_RINSE(TRNS), .T_DRY(TDRY),
      .T_FILL_MAX(TFIL), .T_DRAIN_MAX(TDRN)
   ) dut (
      .clk(clk), .reset_n(reset_n), .tick(tick), .start(start),
      .pause(pause), .abort(abort), .door_closed(door_closed),
      .lvl_high(lvl_high), .lvl_low(lvl_low),
      .valve_in(valve_in), .pump_wash(pump_wash),
      .pump_drain(pump_drain), .heater(heater), .fan(fan),
      .busy(busy), .done(done), .err(err), .phase(phase),
      .remaining(remaining)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit st, pz, ab, dr, lh, ll, tk;
   } in_t;

   typedef struct {
      in_t        i;
      logic [18:0] exp;
   } vec_t;

   vec_t tbl[$];

   // behavioural model: phase number, elapsed ticks, pass, abort, pause
   int   m_ph, m_t;
   bit   m_pass, m_ab, m_pz;
   int   dur[8];
   logic [4:0] act_tab[8];

   function automatic in_t mk(bit st, bit pz, bit ab, bit dr,
                              bit lh, bit ll, bit tk);
      in_t v;
      v.st = st; v.pz = pz; v.ab = ab; v.dr = dr;
      v.lh = lh; v.ll = ll; v.tk = tk;
      return v;
   endfunction

   function automatic logic [18:0] E(logic [2:0] ph, logic [4:0] a,
                                     logic [2:0] b, logic [7:0] r);
      return {ph, a, b, r};
   endfunction

   function automatic logic [18:0] dut_out();
      return {phase, valve_in, pump_wash, pump_drain, heater, fan,
              busy, done, err, remaining};
   endfunction

   function automatic logic [18:0] model_out();
      bit run;
      logic [4:0] a;
      logic [7:0] r;
      run = (m_ph >= 1 && m_ph <= 5);
      a = m_pz ? 5'b0 : act_tab[m_ph];
      r = (dur[m_ph] != 0) ? 8'(dur[m_ph] - m_t) : 8'd0;
      return {3'(m_ph), a, run, (m_ph == 6), (m_ph == 7), r};
   endfunction

   task automatic model_step(input in_t v, input bit rn);
      int nph;
      bit run;
      if (!rn) begin
         m_ph = 0; m_t = 0; m_pass = 0; m_ab = 0; m_pz = 0;
         return;
      end
      run = (m_ph >= 1 && m_ph <= 5);
      nph = m_ph;
      if (v.ab) begin
         if (run) begin
            nph = 3;
            m_ab = 1;
         end else if (m_ph >= 6) begin
            nph = 0;
         end
      end else if (!m_pz) begin
         if (m_ph == 0) begin
            if (v.st && v.dr) begin
               nph = 1;
               m_pass = 0;
            end
         end else if (m_ph == 1) begin
            if (v.lh) nph = m_pass ? 4 : 2;
            else if (v.tk && m_t + 1 == TFIL) nph = 7;
         end else if (dur[m_ph] != 0) begin
            if (v.tk && m_t + 1 == dur[m_ph]) nph = (m_ph == 5) ? 6 : 3;
         end else if (m_ph == 3) begin
            if (v.ll) begin
               if (m_ab) nph = 0;
               else if (!m_pass) begin
                  nph = 1;
                  m_pass = 1;
               end else nph = 5;
            end else if (v.tk && m_t + 1 == TDRN) nph = 7;
         end else if (m_ph == 6) begin
            nph = 0;
         end
      end
      if (nph == 0) m_ab = 0;
      if (nph != m_ph) m_t = 0;
      else if (v.tk && !m_pz) m_t = (m_t < 255) ? m_t + 1 : 255;
      m_pz = run && (v.pz || !v.dr);
      m_ph = nph;
   endtask

   task automatic step(input in_t v, input bit rn);
      reset_n = rn;
      start = v.st; pause = v.pz; abort = v.ab; door_closed = v.dr;
      lvl_high = v.lh; lvl_low = v.ll; tick = v.tk;
      model_step(v, rn);
      @(posedge clk);
      #1;
   endtask

   task automatic go(input bit st, pz, ab, dr, lh, ll, tk);
      step(mk(st, pz, ab, dr, lh, ll, tk), 1'b1);
   endtask

   task automatic rst();
      step(mk(0, 0, 0, 1, 0, 0, 0), 1'b0);
   endtask

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic addv(input in_t v, input logic [18:0] e);
      vec_t x;
      x.i = v;
      x.exp = e;
      tbl.push_back(x);
   endtask

   initial begin
      dur = '{0, 0, TWSH, 0, TRNS, TDRY, 0, 0};
      act_tab = '{5'b00000, 5'b10000, 5'b01010, 5'b00100,
                  5'b01000, 5'b00011, 5'b00000, 5'b00000};

      // full cycle, tick every cycle
      addv(mk(1,0,0,1,0,0,1), E(1, 5'b10000, 3'b100, 0));
      addv(mk(0,0,0,1,0,0,1), E(1, 5'b10000, 3'b100, 0));
      addv(mk(0,0,0,1,0,0,1), E(1, 5'b10000, 3'b100, 0));
      addv(mk(0,0,0,1,1,0,1), E(2, 5'b01010, 3'b100, 4));
      addv(mk(0,0,0,1,0,0,1), E(2, 5'b01010, 3'b100, 3));
      addv(mk(0,0,0,1,0,0,1), E(2, 5'b01010, 3'b100, 2));
      addv(mk(0,0,0,1,0,0,1), E(2, 5'b01010, 3'b100, 1));
      addv(mk(0,0,0,1,0,0,1), E(3, 5'b00100, 3'b100, 0));
      addv(mk(0,0,0,1,0,0,1), E(3, 5'b00100, 3'b100, 0));
      addv(mk(0,0,0,1,0,1,1), E(1, 5'b10000, 3'b100, 0));
      addv(mk(0,0,0,1,0,0,1), E(1, 5'b10000, 3'b100, 0));
      addv(mk(0,0,0,1,1,0,1), E(4, 5'b01000, 3'b100, 3));
      addv(mk(0,0,0,1,0,0,1), E(4, 5'b01000, 3'b100, 2));
      addv(mk(0,0,0,1,0,0,1), E(4, 5'b01000, 3'b100, 1));
      addv(mk(0,0,0,1,0,0,1), E(3, 5'b00100, 3'b100, 0));
      addv(mk(0,0,0,1,0,1,1), E(5, 5'b00011, 3'b100, 2));
      addv(mk(0,0,0,1,0,0,1), E(5, 5'b00011, 3'b100, 1));
      addv(mk(0,0,0,1,0,0,1), E(6, 5'b00000, 3'b010, 0));
      addv(mk(0,0,0,1,0,0,1), E(0, 5'b00000, 3'b000, 0));

      rst();
      chk("reset_outputs", dut_out(), 0);
      foreach (tbl[k]) begin
         step(tbl[k].i, 1'b1);
         chk($sformatf("full_cycle_v%0d", k), dut_out(), tbl[k].exp);
      end

      // fill timeout
      rst();
      go(1,0,0,1,0,0,0);
      chk("fill_entry", phase, 1);
      for (int k = 1; k <= 4; k++) begin
         go(0,0,0,1,0,0,1);
         chk($sformatf("fill_tick%0d", k), phase, 1);
      end
      go(0,0,0,1,0,0,1);
      chk("fill_timeout", dut_out(), E(7, 5'b0, 3'b001, 0));
      go(0,0,0,1,0,0,1);
      chk("error_held", dut_out(), E(7, 5'b0, 3'b001, 0));
      go(0,0,1,1,0,0,0);
      chk("error_abort", dut_out(), 0);

      // pause by door open during wash
      rst();
      go(1,0,0,1,0,0,0);
      go(0,0,0,1,1,0,0);
      go(0,0,0,1,0,0,1);
      go(0,0,0,1,0,0,1);
      chk("wash_rem2", dut_out(), E(2, 5'b01010, 3'b100, 2));
      go(0,0,0,0,0,0,0);
      chk("door_open", dut_out(), E(2, 5'b00000, 3'b100, 2));
      for (int k = 0; k < 3; k++) begin
         go(0,0,0,0,0,0,1);
         chk($sformatf("paused_tick%0d", k), dut_out(),
             E(2, 5'b00000, 3'b100, 2));
      end
      go(0,0,0,1,0,0,0);
      chk("door_closed", dut_out(), E(2, 5'b01010, 3'b100, 2));
      go(0,0,0,1,0,0,1);
      chk("resume_rem1", dut_out(), E(2, 5'b01010, 3'b100, 1));
      go(0,0,0,1,0,0,1);
      chk("resume_end", phase, 3);

      // abort during rinse
      rst();
      go(1,0,0,1,0,0,0);
      go(0,0,0,1,1,0,0);
      for (int k = 0; k < 4; k++) go(0,0,0,1,0,0,1);
      chk("ab_drain1", phase, 3);
      go(0,0,0,1,0,1,0);
      go(0,0,0,1,1,0,0);
      chk("ab_rinse", phase, 4);
      go(0,0,1,1,0,0,0);
      chk("ab_to_drain", dut_out(), E(3, 5'b00100, 3'b100, 0));
      go(0,0,0,1,0,1,0);
      chk("ab_to_idle", dut_out(), 0);
      go(0,0,0,1,0,0,1);
      chk("ab_no_done", dut_out(), 0);

      // abort, pause and tick together in wash
      rst();
      go(1,0,0,1,0,0,0);
      go(0,0,0,1,1,0,0);
      go(0,1,1,1,0,0,1);
      chk("sim_drain", dut_out(), E(3, 5'b00000, 3'b100, 0));
      go(0,0,0,1,0,0,0);
      chk("sim_unpause", dut_out(), E(3, 5'b00100, 3'b100, 0));
      go(0,0,0,1,0,1,0);
      chk("sim_idle", phase, 0);
      go(1,0,0,0,0,0,1);
      chk("door_open_start", dut_out(), 0);

      // reset in the middle of dry
      rst();
      go(1,0,0,1,0,0,0);
      go(0,0,0,1,1,0,0);
      for (int k = 0; k < 4; k++) go(0,0,0,1,0,0,1);
      go(0,0,0,1,0,1,0);
      go(0,0,0,1,1,0,0);
      for (int k = 0; k < 3; k++) go(0,0,0,1,0,0,1);
      go(0,0,0,1,0,1,0);
      chk("rst_in_dry", phase, 5);
      rst();
      chk("rst_mid_dry", dut_out(), 0);
      go(1,0,0,1,0,0,0);
      go(0,0,0,1,1,0,0);
      chk("rst_pass0", phase, 2);

      // random stimulus against the model
      rst();
      for (int k = 0; k < 4000; k++) begin
         in_t v;
         bit rn;
         v.st = ($urandom_range(3) == 0);
         v.pz = ($urandom_range(15) == 0);
         v.ab = ($urandom_range(39) == 0);
         v.dr = ($urandom_range(15) != 0);
         v.lh = ($urandom_range(5) == 0);
         v.ll = ($urandom_range(5) == 0);
         v.tk = ($urandom_range(1) == 0);
         rn = ($urandom_range(199) != 0);
         step(v, rn);
         chk($sformatf("rand%0d", k), dut_out(), model_out());
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/wash_cycle_sequencer.md
WASH_CYCLE_SEQUENCER -- requirements
Module: wash_cycle_sequencer

Interface
REQ-001 SHALL have parameter TW, default 8, timer/count width in bits.
REQ-002 SHALL have parameter T_WASH, default 20, wash duration in ticks.
REQ-003 SHALL have parameter T_RINSE, default 10, rinse duration in ticks.
REQ-004 SHALL have parameter T_DRY, default 15, dry duration in ticks.
REQ-005 SHALL have parameter T_FILL_MAX, default 30, fill timeout in ticks.
REQ-006 SHALL have parameter T_DRAIN_MAX, default 30, drain timeout in ticks.
REQ-007 SHALL have port clk, input, 1, single system clock, all logic on rising edge.
REQ-008 SHALL have port reset_n, input, 1; reset is synchronous and active-low.
REQ-009 SHALL have port tick, input, 1, one-cycle time-base enable (e.g. 1 s).
REQ-010 SHALL have port start, input, 1, begin a cycle from IDLE.
REQ-011 SHALL have port pause, input, 1, level, hold current phase.
REQ-012 SHALL have port abort, input, 1, cancel cycle / clear error.
REQ-013 SHALL have port door_closed, input, 1, 1 = door shut.
REQ-014 SHALL have port lvl_high, input, 1, tank full sensor.
REQ-015 SHALL have port lvl_low, input, 1, tank empty sensor.
REQ-016 SHALL have outputs valve_in, pump_wash, pump_drain, heater, fan, each 1 bit, actuator enables.
REQ-017 SHALL have outputs busy (1), done (1), err (1), phase (3), remaining (TW), status.

Function
REQ-018 SHALL implement states IDLE=0, FILL=1, WASH=2, DRAIN=3, RINSE=4, DRY=5, DONE=6, ERROR=7; phase SHALL equal the state encoding.
REQ-019 SHALL hold an internal pass bit (0 = wash pass, 1 = rinse pass) and an abort flag.
REQ-020 SHALL use one TW-bit phase timer, cleared on every state change, incremented on tick when not paused, saturating at all-ones.
REQ-021 IDLE: start=1 and door_closed=1 -> FILL, pass=0; start with door open is ignored.
REQ-022 FILL: lvl_high=1 -> WASH if pass=0, else RINSE; timer reaching T_FILL_MAX -> ERROR.
REQ-023 WASH/RINSE/DRY: exit on the tick edge where timer = T-1, so each phase lasts exactly T ticks; WASH/RINSE -> DRAIN, DRY -> DONE.
REQ-024 DRAIN: lvl_low=1 -> IDLE if abort flag set, else FILL with pass=1 if pass=0, else DRY; timer reaching T_DRAIN_MAX -> ERROR.
REQ-025 DONE: lasts exactly one cycle, then IDLE.
REQ-026 ERROR: held until abort=1, then IDLE; all actuators off.
REQ-027 abort=1 in FILL/WASH/RINSE/DRY SHALL go to DRAIN, set the abort flag; abort in DRAIN sets the flag only.
REQ-028 Registered paused flag SHALL be set each cycle to (state in FILL..DRY) and (pause or not door_closed); while paused, state and timer are frozen and all actuators off.
REQ-029 Priority within a cycle SHALL be: reset > abort > paused > sensor/timer transition.
REQ-030 Actuator decode (not paused): FILL valve_in; WASH pump_wash+heater; RINSE pump_wash; DRAIN pump_drain; DRY fan+heater; all else 0.
REQ-031 Sensor checks SHALL take precedence over timeout when both are true in the same cycle.
REQ-032 busy SHALL be 1 in FILL..DRY; done SHALL be 1 only in DONE; err SHALL be 1 only in ERROR.
REQ-033 remaining SHALL be T minus timer in WASH/RINSE/DRY, 0 elsewhere.
REQ-034 All outputs SHALL be decoded from registered state only, with no combinational input-to-output path.

Reset
REQ-035 reset_n=0 at a clock edge SHALL force IDLE, timer=0, pass=0, abort flag=0, paused=0; all outputs 0, including mid-cycle.

Verification (bench params T_WASH=4, T_RINSE=3, T_DRY=2, T_FILL_MAX=5, T_DRAIN_MAX=5)
REQ-036 Full cycle: start, lvl_high after 2 ticks, lvl_low after 1 tick each drain -> phase 0,1,2,3,1,4,3,5,6,0; WASH 4 ticks, RINSE 3, DRY 2; done high one cycle.
REQ-037 Fill timeout: start, lvl_high never asserted -> ERROR on the 5th tick, err=1, actuators 0; abort -> IDLE.
REQ-038 Pause: door_closed=0 for 3 ticks during WASH at remaining=2 -> actuators 0, remaining stays 2; door closed -> WASH resumes and lasts 2 more ticks.
REQ-039 Abort in RINSE -> DRAIN with pump_drain=1; lvl_low -> IDLE, no DRY, done stays 0.
REQ-040 Simultaneous: abort, pause and tick in the same WASH cycle -> DRAIN next cycle; start with door open in IDLE -> stays IDLE.
REQ-041 Reset mid-DRY: reset_n=0 for one edge -> IDLE, all outputs 0, next start begins at pass 0.
